// File: rtl/exe_pkg.sv
// Shared types and constants for the execution-unit command issuer.
// Widths here are the defaults of the exe unit this issuer is paired with.
package exe_pkg;

   localparam int EXE_M    = 4;  // operand/result width
   localparam int EXE_N    = 2;  // opcode width
   localparam int STATUS_W = 4;  // exe unit status nibble

   typedef logic [EXE_N-1:0] oper_t;

   localparam oper_t OPER_0 = 2'd0;
   localparam oper_t OPER_1 = 2'd1;
   localparam oper_t OPER_2 = 2'd2;
   localparam oper_t OPER_3 = 2'd3;

   // One queued command, packed as it sits in the command FIFO.
   typedef struct packed {
      oper_t            oper;
      logic [EXE_M-1:0] arg_a;
      logic [EXE_M-1:0] arg_b;
   } cmd_t;

   // One captured exe unit response, packed as it sits in the response FIFO.
   typedef struct packed {
      logic [EXE_M-1:0]    result;
      logic [STATUS_W-1:0] status;
   } rsp_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count.
// A push while full is accepted only when a pop happens on the same edge;
// a pop while empty is ignored. Storage is cleared on reset so the read
// data port shows zero until the first push.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rd_ptr];

   // Storage write; entries are only overwritten at the write pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   // Occupancy: simultaneous push and pop leaves the count unchanged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else begin
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/exe_cmd_issuer.sv
// Initiator side of the exe unit operand interface.
// Commands are buffered, issued one per cycle into a 1-cycle registered exe
// unit, and the results come back in issue order through a response FIFO.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; ready never depends combinationally on the same port's valid.
//
// Issue is credit limited: a command only leaves the command FIFO if the
// response FIFO is guaranteed room for it, counting results already in the
// exe pipeline (v1 = operands on the exe inputs, v2 = exe output valid).
module exe_cmd_issuer
   import exe_pkg::*;
#(
   parameter int m         = EXE_M,
   parameter int n         = EXE_N,
   parameter int CMD_DEPTH = 4,
   parameter int RSP_DEPTH = 4
) (
   input  logic                i_clk,
   input  logic                i_rsn,
   input  logic                i_cmd_valid,
   output logic                o_cmd_ready,
   input  logic [n-1:0]        i_cmd_oper,
   input  logic [m-1:0]        i_cmd_argA,
   input  logic [m-1:0]        i_cmd_argB,
   output logic [n-1:0]        o_oper,
   output logic [m-1:0]        o_argA,
   output logic [m-1:0]        o_argB,
   input  logic [m-1:0]        i_exe_result,
   input  logic [STATUS_W-1:0] i_exe_status,
   output logic                o_rsp_valid,
   input  logic                i_rsp_ready,
   output logic [m-1:0]        o_rsp_result,
   output logic [STATUS_W-1:0] o_rsp_status,
   output logic                o_busy
);

   localparam int CMD_W = n + 2 * m;
   localparam int RSP_W = m + STATUS_W;
   localparam int CCW   = $clog2(CMD_DEPTH) + 1;
   localparam int RCW   = $clog2(RSP_DEPTH) + 1;
   localparam int OW    = RCW + 1;

   // Command side
   logic             ready_en;
   logic             cmd_push;
   logic             cmd_pop;
   logic             cmd_full;
   logic             cmd_empty;
   logic [CCW-1:0]   cmd_count;
   logic [CMD_W-1:0] cmd_wdata;
   logic [CMD_W-1:0] cmd_rdata;
   logic [n-1:0]     head_oper;
   logic [m-1:0]     head_a;
   logic [m-1:0]     head_b;

   // Response side
   logic             rsp_push;
   logic             rsp_pop;
   logic             rsp_full;
   logic             rsp_empty;
   logic [RCW-1:0]   rsp_count;
   logic [RSP_W-1:0] rsp_wdata;
   logic [RSP_W-1:0] rsp_rdata;

   // Exe pipeline tracking and credit
   logic             v1;
   logic             v2;
   logic [OW-1:0]    occ;
   logic             credit_ok;

   // Ready is held low through reset and rises on the first edge after it.
   assign o_cmd_ready = ready_en & ~cmd_full;
   assign cmd_push    = i_cmd_valid & o_cmd_ready;
   assign cmd_wdata   = {i_cmd_oper, i_cmd_argA, i_cmd_argB};
   assign {head_oper, head_a, head_b} = cmd_rdata;

   assign o_rsp_valid = ~rsp_empty;
   assign rsp_pop     = o_rsp_valid & i_rsp_ready;
   assign rsp_push    = v2;
   assign rsp_wdata   = {i_exe_result, i_exe_status};
   assign {o_rsp_result, o_rsp_status} = rsp_rdata;

   assign o_busy = ~cmd_empty | v1 | v2;

   sync_fifo #(
      .WIDTH (CMD_W),
      .DEPTH (CMD_DEPTH)
   ) u_cmd_fifo (
      .clk   (i_clk),
      .rst_n (i_rsn),
      .push  (cmd_push),
      .pop   (cmd_pop),
      .wdata (cmd_wdata),
      .rdata (cmd_rdata),
      .full  (cmd_full),
      .empty (cmd_empty),
      .count (cmd_count)
   );

   sync_fifo #(
      .WIDTH (RSP_W),
      .DEPTH (RSP_DEPTH)
   ) u_rsp_fifo (
      .clk   (i_clk),
      .rst_n (i_rsn),
      .push  (rsp_push),
      .pop   (rsp_pop),
      .wdata (rsp_wdata),
      .rdata (rsp_rdata),
      .full  (rsp_full),
      .empty (rsp_empty),
      .count (rsp_count)
   );

   // Credit check: responses held after this cycle's pop plus results still
   // in the exe pipeline must leave at least one free slot for a new issue.
   // A full FIFO with no pop has no room whatever is in flight.
   always_comb begin
      occ       = '0;
      credit_ok = 1'b0;
      cmd_pop   = 1'b0;
      occ       = OW'(rsp_count) - OW'(rsp_pop) + OW'(v1) + OW'(v2);
      credit_ok = (occ < OW'(RSP_DEPTH)) && !(rsp_full && !rsp_pop);
      cmd_pop   = (cmd_count != '0) && credit_ok;
   end

   // Output ready enable: low in reset, high from the first edge after.
   always_ff @(posedge i_clk or negedge i_rsn) begin
      if (!i_rsn) begin
         ready_en <= 1'b0;
      end else begin
         ready_en <= 1'b1;
      end
   end

   // Operand registers load the FIFO head on issue and hold otherwise.
   always_ff @(posedge i_clk or negedge i_rsn) begin
      if (!i_rsn) begin
         o_oper <= '0;
         o_argA <= '0;
         o_argB <= '0;
      end else if (cmd_pop) begin
         o_oper <= head_oper;
         o_argA <= head_a;
         o_argB <= head_b;
      end
   end

   // Pipeline valids: v1 marks fresh operands, v2 marks a valid exe result.
   always_ff @(posedge i_clk or negedge i_rsn) begin
      if (!i_rsn) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
      end else begin
         v1 <= cmd_pop;
         v2 <= v1;
      end
   end

endmodule

// File: tb/tb_exe_cmd_issuer.sv
// Bench for exe_cmd_issuer wired to a behavioural 1-cycle exe unit.
// Expected responses are the exe function of each accepted command, kept in
// accept order; a negedge monitor compares every response that leaves.
module tb_exe_cmd_issuer;

   logic       clk;
   logic       rst_n;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_oper;
   logic [3:0] cmd_a;
   logic [3:0] cmd_b;
   logic [1:0] exe_oper;
   logic [3:0] exe_a;
   logic [3:0] exe_b;
   logic [3:0] exe_result;
   logic [3:0] exe_status;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [3:0] rsp_result;
   logic [3:0] rsp_status;
   logic       busy;

   int         tests;
   int         fails;
   int         cyc;
   int         rsp_seen;
   int         accepted;
   logic [7:0] exp_q[$];
   int         rsp_cyc_q[$];
   int         acc_cyc_q[$];

   exe_cmd_issuer dut (
      .i_clk        (clk),
      .i_rsn        (rst_n),
      .i_cmd_valid  (cmd_valid),
      .o_cmd_ready  (cmd_ready),
      .i_cmd_oper   (cmd_oper),
      .i_cmd_argA   (cmd_a),
      .i_cmd_argB   (cmd_b),
      .o_oper       (exe_oper),
      .o_argA       (exe_a),
      .o_argB       (exe_b),
      .i_exe_result (exe_result),
      .i_exe_status (exe_status),
      .o_rsp_valid  (rsp_valid),
      .i_rsp_ready  (rsp_ready),
      .o_rsp_result (rsp_result),
      .o_rsp_status (rsp_status),
      .o_busy       (busy)
   );

   // Exe unit function: add, subtract, and, xor; status = {carry, zero, neg, ovf}.
   function automatic logic [7:0] exe_fn(input logic [1:0] op, input logic [3:0] a,
                                         input logic [3:0] b);
      int sa, sb, sr, ua, ub, ur;
      logic [3:0] r;
      logic c, v;
      ua = int'(a); ub = int'(b);
      sa = (ua > 7) ? ua - 16 : ua;
      sb = (ub > 7) ? ub - 16 : ub;
      c = 1'b0; v = 1'b0;
      case (op)
         2'd0: begin
            ur = ua + ub; c = (ur > 15); sr = sa + sb; v = (sr > 7) || (sr < -8);
            r = 4'(ur);
         end
         2'd1: begin
            ur = ua - ub; c = (ur < 0); sr = sa - sb; v = (sr > 7) || (sr < -8);
            r = 4'(ur);
         end
         2'd2: r = a & b;
         default: r = a ^ b;
      endcase
      return {r, c, (r == 4'd0), r[3], v};
   endfunction

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Edge counter used for latency and timing checks
   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural exe unit: registered, synchronous reset
   always @(posedge clk) begin
      if (!rst_n) begin
         exe_result <= 4'd0;
         exe_status <= 4'd0;
      end else begin
         {exe_result, exe_status} <= exe_fn(exe_oper, exe_a, exe_b);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every response leaving the DUT is compared against the queue head
   always @(negedge clk) begin
      if (rst_n === 1'b1 && rsp_valid && rsp_ready) begin
         rsp_seen++;
         rsp_cyc_q.push_back(cyc);
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_rsp: got %0h expected none", {rsp_result, rsp_status});
         end else begin
            check("rsp_data", {24'd0, rsp_result, rsp_status}, {24'd0, exp_q.pop_front()});
         end
      end
   end

   // Driver: present a command, wait for ready (bounded), record expectation
   task automatic send(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                       input int budget);
      int k;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_oper  = op;
      cmd_a     = a;
      cmd_b     = b;
      k = 0;
      while (!cmd_ready && k < budget) begin
         @(negedge clk);
         k++;
      end
      if (!cmd_ready) begin
         tests++;
         fails++;
         $display("FAIL cmd_accept_timeout: got ready 0 expected 1");
         cmd_valid = 1'b0;
         return;
      end
      exp_q.push_back(exe_fn(op, a, b));
      @(posedge clk);
      #1;
      accepted++;
      acc_cyc_q.push_back(cyc);
      cmd_valid = 1'b0;
   endtask

   task automatic set_rsp_ready(input logic val);
      @(posedge clk);
      #1;
      rsp_ready = val;
   endtask

   task automatic wait_drain(input int budget);
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < budget) begin
         @(negedge clk);
         k++;
      end
      check("drain_done", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd0);
      check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
      check({tag, "_busy"},      {31'd0, busy},      32'd0);
      check({tag, "_ops"},       {22'd0, exe_oper, exe_a, exe_b}, 32'd0);
      check({tag, "_rsp_data"},  {24'd0, rsp_result, rsp_status}, 32'd0);
   endtask

   initial begin
      int k;
      int base;
      int r_cyc;
      int bp_done;
      tests = 0; fails = 0; rsp_seen = 0; accepted = 0;
      cmd_valid = 1'b0; cmd_oper = 2'd0; cmd_a = 4'd0; cmd_b = 4'd0;
      rsp_ready = 1'b0;
      rst_n = 1'b0;

      // Power-on reset
      #1;
      check_reset_outputs("por");
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("por_ready_before_edge", {31'd0, cmd_ready}, 32'd0);
      @(negedge clk);
      check("por_ready_after_edge", {31'd0, cmd_ready}, 32'd1);

      // Single command: latency and single pulse
      set_rsp_ready(1'b1);
      send(2'b00, 4'h3, 4'h5, 20);
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!rsp_valid && k < 20);
      check("single_latency", 32'(k), 32'd4);
      @(negedge clk);
      check("single_pulse", {31'd0, rsp_valid}, 32'd0);
      check("single_idle_busy", {31'd0, busy}, 32'd0);

      // All opcodes with wrapping operands
      for (int op = 0; op < 4; op++) begin
         send(2'(op), 4'hF, 4'h1, 20);
      end
      wait_drain(40);

      // Back-to-back random stream with the consumer always ready
      rsp_cyc_q.delete();
      for (int i = 0; i < 16; i++) begin
         send(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
              4'($urandom_range(0, 15)), 20);
      end
      wait_drain(60);
      check("stream_count", 32'(rsp_cyc_q.size()), 32'd16);
      if (rsp_cyc_q.size() == 16) begin
         check("stream_span", 32'(rsp_cyc_q[15] - rsp_cyc_q[0]), 32'd15);
      end

      // Backpressure: 4 held responses + 4 queued commands, then stall
      set_rsp_ready(1'b0);
      accepted = 0;
      acc_cyc_q.delete();
      base = rsp_seen;
      bp_done = 0;
      fork
         begin
            for (int i = 0; i < 10; i++) begin
               send(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                    4'($urandom_range(0, 15)), 200);
            end
            bp_done = 1;
         end
      join_none
      repeat (20) @(negedge clk);
      check("bp_accepted", 32'(accepted), 32'd8);
      check("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp_busy", {31'd0, busy}, 32'd1);
      check("bp_no_rsp", 32'(rsp_seen - base), 32'd0);

      // Release: the pop edge frees a command slot but ready stays low that cycle
      @(posedge clk);
      #1;
      r_cyc = cyc;
      rsp_ready = 1'b1;
      @(negedge clk);
      check("full_pop_ready", {31'd0, cmd_ready}, 32'd0);
      k = 0;
      while (bp_done == 0 && k < 100) begin
         @(negedge clk);
         k++;
      end
      check("bp_sender_done", 32'(bp_done), 32'd1);
      if (acc_cyc_q.size() >= 9) begin
         check("full_next_accept", 32'(acc_cyc_q[8]), 32'(r_cyc + 2));
      end
      wait_drain(60);
      check("bp_delivered", 32'(rsp_seen - base), 32'd10);

      // Reset mid-stream with commands queued and in flight
      set_rsp_ready(1'b0);
      send(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 20);
      send(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 20);
      send(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 20);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("mid");
      exp_q.delete();
      base = rsp_seen;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("mid_busy_after", {31'd0, busy}, 32'd0);
      check("mid_ready_before_edge", {31'd0, cmd_ready}, 32'd0);
      @(negedge clk);
      check("mid_ready_after_edge", {31'd0, cmd_ready}, 32'd1);
      set_rsp_ready(1'b1);
      repeat (10) @(negedge clk);
      check("mid_no_stale", 32'(rsp_seen - base), 32'd0);

      // Post-reset traffic still works
      for (int i = 0; i < 6; i++) begin
         send(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
              4'($urandom_range(0, 15)), 20);
      end
      wait_drain(40);
      check("post_reset_count", 32'(rsp_seen - base), 32'd6);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
